// File: rtl/decim_polyphase_ctrl.sv
// Sequencer for a D-branch polyphase decimator: commutates input samples into frames,
// pulses the shared branch enable, drops warm-up outputs and sums the branch lanes.
// Optional synchronous restart through the flush port is compiled in with DECIM_FLUSH_EN.
module decim_polyphase_ctrl #(
  parameter int D    = 4,
  parameter int IN_W = 8,
  parameter int BR_W = 17,
  parameter int WARM = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [IN_W-1:0]           in_data,
  output logic                      in_ready,
  output logic [D*IN_W-1:0]         branch_x,
  output logic                      branch_ce,
  input  logic [D*BR_W-1:0]         branch_y,
  output logic                      out_valid,
  output logic [BR_W+$clog2(D)-1:0] out_data,
  input  logic                      out_ready,
  input  logic                      flush
);
  localparam int PW = $clog2(D);
  localparam int SW = BR_W + PW;
  localparam int WW = (WARM > 0) ? $clog2(WARM + 1) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(D - 1);
  localparam logic [WW-1:0] WARM_LAST  = WW'((WARM > 0) ? WARM - 1 : 0);

  typedef enum logic {
    S_WARM = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // With no branch pipeline latency there is nothing to discard.
  localparam state_t INIT_STATE = (WARM == 0) ? S_RUN : S_WARM;

  logic [D*IN_W-1:0] frame_reg;
  logic [PW-1:0]     phase_reg;
  logic              frame_full_reg;
  logic              alive_reg;
  logic              ce_d1_reg;
  logic [WW-1:0]     warm_reg;
  state_t            state_reg;
  logic              out_valid_reg;
  logic [SW-1:0]     out_data_reg;

  logic              flush_act;
  logic              accept;
  logic              slot_free;
  logic [SW-1:0]     lane_ext [D];
  logic [SW-1:0]     branch_sum;

`ifdef DECIM_FLUSH_EN
  assign flush_act = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  assign in_ready  = alive_reg & ~frame_full_reg & ~flush_act;
  assign accept    = in_valid & in_ready;
  assign slot_free = ~ce_d1_reg & ~(out_valid_reg & ~out_ready);
  assign branch_ce = frame_full_reg & slot_free & ~flush_act;

  assign branch_x  = frame_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_ext
      assign lane_ext[gi] = {{PW{branch_y[gi*BR_W + BR_W - 1]}}, branch_y[gi*BR_W +: BR_W]};
    end
  endgenerate

  // The widened accumulator cannot overflow, so plain modular addition is exact.
  always_comb begin
    branch_sum = '0;
    for (int k = 0; k < D; k++) begin
      branch_sum = branch_sum + lane_ext[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_reg <= '0;
    end else if (flush_act) begin
      frame_reg <= '0;
    end else if (accept) begin
      for (int k = 0; k < D; k++) begin
        if (phase_reg == PW'(k)) begin
          frame_reg[k*IN_W +: IN_W] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_reg      <= 1'b0;
      phase_reg      <= '0;
      frame_full_reg <= 1'b0;
      ce_d1_reg      <= 1'b0;
      warm_reg       <= '0;
      state_reg      <= INIT_STATE;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
    end else begin
      alive_reg <= 1'b1;
      if (flush_act) begin
        phase_reg      <= '0;
        frame_full_reg <= 1'b0;
        ce_d1_reg      <= 1'b0;
        warm_reg       <= '0;
        state_reg      <= INIT_STATE;
        out_valid_reg  <= 1'b0;
        out_data_reg   <= '0;
      end else begin
        ce_d1_reg <= branch_ce;

        // accept and branch_ce are mutually exclusive: one needs frame_full low, the other high.
        if (branch_ce) begin
          frame_full_reg <= 1'b0;
        end else if (accept && phase_reg == LAST_PHASE) begin
          frame_full_reg <= 1'b1;
        end

        if (accept) begin
          phase_reg <= (phase_reg == LAST_PHASE) ? '0 : phase_reg + 1'b1;
        end

        if (out_valid_reg && out_ready) begin
          out_valid_reg <= 1'b0;
        end

        if (ce_d1_reg) begin
          case (state_reg)
            S_WARM: begin
              warm_reg <= warm_reg + 1'b1;
              if (warm_reg == WARM_LAST) begin
                state_reg <= S_RUN;
              end
            end
            S_RUN: begin
              out_valid_reg <= 1'b1;
              out_data_reg  <= branch_sum;
            end
            default: state_reg <= INIT_STATE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_decim_polyphase_ctrl.sv
// Scoreboard bench for decim_polyphase_ctrl: stub branches (lane k = (k+1)*x_k or forced),
// expected frames/sums queued at stimulus time and popped by monitors on branch_ce / output handshakes.
module tb_decim_polyphase_ctrl;
  localparam int D    = 4;
  localparam int IN_W = 8;
  localparam int BR_W = 17;
  localparam int WARM = 3;
  localparam int SW   = BR_W + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_ready;
  logic [D*IN_W-1:0] branch_x;
  logic              branch_ce;
  logic [D*BR_W-1:0] branch_y;
  logic              out_valid;
  logic [SW-1:0]     out_data;
  logic              out_ready = 1'b1;
  logic              flush = 1'b0;

  decim_polyphase_ctrl #(.D(D), .IN_W(IN_W), .BR_W(BR_W), .WARM(WARM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .branch_x(branch_x), .branch_ce(branch_ce), .branch_y(branch_y),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub branch bank: registers branch_x on branch_ce like a one-stage filter.
  logic signed [BR_W-1:0] stub_reg [D];
  logic signed [BR_W-1:0] force_val [D];
  logic stub_force = 1'b0;

  always @(posedge clk) begin
    if (branch_ce) begin
      for (int k = 0; k < D; k++) begin
        stub_reg[k] <= BR_W'((k + 1) * $signed(branch_x[k*IN_W +: IN_W]));
      end
    end
  end

  always_comb begin
    branch_y = '0;
    for (int k = 0; k < D; k++) begin
      branch_y[k*BR_W +: BR_W] = stub_force ? force_val[k] : stub_reg[k];
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input longint act, input longint exp);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Scoreboard
  logic [D*IN_W-1:0] frame_q [$];
  longint            out_q [$];
  int                ce_count = 0;
  int                out_count = 0;
  logic [D*IN_W-1:0] last_ce_x = '0;
  longint            last_out = 0;

  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && branch_ce) begin
      ce_count++;
      last_ce_x = branch_x;
      if (frame_q.size() == 0) fail("ce_unexpected", longint'(branch_x), 0);
      else check("branch_x", longint'(branch_x), longint'(frame_q.pop_front()));
    end
    if (rst_n && out_valid && out_ready) begin
      out_count++;
      last_out = longint'($signed(out_data));
      $display("out #%0d data=%0d", out_count, last_out);
      if (out_q.size() == 0) fail("out_unexpected", last_out, 0);
      else check("out_data", last_out, out_q.pop_front());
    end
  end

  // Driver-side model of the commutator and warm-up.
  logic [IN_W-1:0] cur [D];
  int tb_phase = 0;
  int frames_done = 0;

  task automatic send(input int v);
    int n;
    logic [D*IN_W-1:0] f;
    longint s;
    n = 0;
    in_valid = 1'b1;
    in_data  = IN_W'(v);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail("send_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cur[tb_phase] = IN_W'(v);
    tb_phase++;
    if (tb_phase == D) begin
      s = 0;
      for (int k = 0; k < D; k++) begin
        f[k*IN_W +: IN_W] = cur[k];
        s += stub_force ? longint'(force_val[k]) : longint'((k + 1) * $signed(cur[k]));
      end
      frame_q.push_back(f);
      frames_done++;
      tb_phase = 0;
      if (frames_done > WARM) out_q.push_back(s);
    end
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int e);
    send(a); send(b); send(c); send(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((frame_q.size() != 0 || out_q.size() != 0) && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("queues_drained", frame_q.size() + out_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_branch_ce"}, branch_ce, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, longint'(out_data), 0);
    check({tag, "_branch_x"}, longint'(branch_x), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int ce0;
    int oc0;
    int tmp;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    // Commutation: lane 0 = oldest sample, in_ready low for one cycle
    send_frame(10, 20, 30, 40);
    check("frame_full_ready", in_ready, 0);
    check("ce_on_frame", branch_ce, 1);
    @(negedge clk);
    check("ready_after_ce", in_ready, 1);
    check("ce_single", branch_ce, 0);
    #2;
    check("lanes_10_20_30_40", longint'(last_ce_x), longint'(32'h281E_140A));
    check("ce_count_1", ce_count, 1);

    // Warm-up: frames 2 and 3 produce nothing, frame 4 appears two edges after accept
    send_frame(-1, -2, -3, -4);
    send_frame(127, -128, 0, 1);
    repeat (6) @(negedge clk);
    check("warm_no_output", out_count, 0);
    send_frame(1, 2, 3, 4);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("out_latency", n, 2);
    drain();
    check("frame4_sum", last_out, 30);
    send_frame(-1, -128, 127, 5);
    drain();
    check("frame5_sum", last_out, 144);

    // Sum of forced branch outputs, including the most negative full-scale case
    force_val[0] = 17'sd100; force_val[1] = -17'sd50; force_val[2] = 17'sd7; force_val[3] = 17'sd1;
    stub_force = 1'b1;
    send_frame(9, 9, 9, 9);
    drain();
    check("sum_58", last_out, 58);
    for (int k = 0; k < D; k++) force_val[k] = -17'sd65536;
    send_frame(9, 9, 9, 9);
    drain();
    check("sum_min_no_wrap", last_out, -262144);
    stub_force = 1'b0;

    // Backpressure: one frame in flight, one buffered, sender stalls
    ce0 = ce_count;
    oc0 = out_count;
    fork
      begin
        for (int i = 1; i <= 12; i++) send(i);
      end
      begin
        out_ready = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid_held", out_valid, 1);
        check("bp_one_ce_in_stall", ce_count - ce0, 1);
        check("bp_no_output", out_count - oc0, 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #2;
        check("bp_single_ce_release", ce_count - ce0, 2);
      end
    join
    drain();
    check("bp_three_outputs", out_count - oc0, 3);
    check("bp_last_sum", last_out, 9 + 2 * 10 + 3 * 11 + 4 * 12);

    // Reset mid-frame: the partial frame is discarded
    oc0 = out_count;
    send(5);
    send(6);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midreset");
    tb_phase = 0;
    frames_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(11, 12, 13, 14);
    drain();
    check("midreset_lanes", longint'(last_ce_x), longint'(32'h0E0D_0C0B));
    check("midreset_warm_no_out", out_count - oc0, 0);

`ifdef DECIM_FLUSH_EN
    // Flush with a held output and a buffered frame
    send_frame(1, 1, 1, 1);
    send_frame(2, 2, 2, 2);
    drain();
    out_ready = 1'b0;
    send_frame(3, 0, 0, 0);
    send_frame(4, 0, 0, 0);
    @(negedge clk);
    #2;
    check("pre_flush_frame_full", in_ready, 0);
    check("pre_flush_out_valid", out_valid, 1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    frame_q.delete();
    out_q.delete();
    tb_phase = 0;
    frames_done = 0;
    #2;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_branch_x", longint'(branch_x), 0);
    @(negedge clk);
    out_ready = 1'b1;
    oc0 = out_count;
    send_frame(1, 2, 3, 4);
    send_frame(1, 2, 3, 4);
    send_frame(1, 2, 3, 4);
    repeat (6) @(negedge clk);
    check("flush_warm_no_out", out_count - oc0, 0);
    send_frame(2, 0, 0, 1);
    drain();
    check("flush_first_sum", last_out, 6);
`endif

    tmp = out_q.size() + frame_q.size();
    check("scoreboard_empty", tmp, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
